// File: rtl/pll_lock_guard_if.sv
// Signal bundle between the PLL lock guard and the PLL/fabric around it.
// slave = guard side, master = PLL/system side.
interface pll_lock_guard_if;
  // No handshake: pll_lock and fb_toggle are free-running asynchronous levels,
  // and every guard output is a registered level, valid on every cycle.
  logic        pll_lock;
  logic        fb_toggle;
  logic        pll_rst;
  logic        sys_rst;
  logic        ready;
  logic [3:0]  fail_cnt;
  logic [11:0] meas;

  modport slave (
    input  pll_lock,
    input  fb_toggle,
    output pll_rst,
    output sys_rst,
    output ready,
    output fail_cnt,
    output meas
  );

  modport master (
    output pll_lock,
    output fb_toggle,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fail_cnt,
    input  meas
  );
endinterface

// File: rtl/pll_lock_guard.sv
// PLL supervisor in the reference-clock domain: resets the PLL, qualifies lock
// and output frequency, then releases the system reset; any failure retries.
module pll_lock_guard #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int WINDOW       = 1000,
  parameter int EXP_EDGES    = 240,
  parameter int TOL          = 4
) (
  input  logic             clk,
  input  logic             reset,
  pll_lock_guard_if.slave  pll_if,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_PRST  = 2'd0,
    ST_WLOCK = 2'd1,
    ST_MEAS  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [19:0] C_RST_LAST  = 20'(RST_CYCLES - 1);
  localparam logic [19:0] C_STAB_LAST = 20'(LOCK_STABLE - 1);
  localparam logic [19:0] C_TO_LAST   = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] C_WIN       = 20'(WINDOW);
  localparam logic [11:0] C_EXP       = 12'(EXP_EDGES);
  localparam logic [11:0] C_TOL       = 12'(TOL);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_lock_m;
  logic        r_lock_s;
  logic        r_tog_m;
  logic        r_tog_s;
  logic        r_tog_d;
  logic        w_edge;

  // r_tmr is shared: PRST length, WLOCK timeout, and 1-based window position.
  logic [19:0] r_tmr;
  logic [19:0] w_tmr_next;
  logic [19:0] r_stab;
  logic [19:0] w_stab_next;
  logic [11:0] r_edges;
  logic [11:0] w_edges_next;
  logic [11:0] w_edges_sum;
  logic [11:0] w_dev;
  logic        w_in_tol;
  logic [11:0] r_meas;
  logic [11:0] w_meas_next;
  logic        w_fail;

  logic [3:0]  r_fail_cnt;
  logic        r_pll_rst;
  logic        r_sys_rst;
  logic        r_ready;

  // Two-flop synchronizers; the toggle gets a third flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
      r_tog_m  <= 1'b0;
      r_tog_s  <= 1'b0;
      r_tog_d  <= 1'b0;
    end else begin
      r_lock_m <= pll_if.pll_lock;
      r_lock_s <= r_lock_m;
      r_tog_m  <= pll_if.fb_toggle;
      r_tog_s  <= r_tog_m;
      r_tog_d  <= r_tog_s;
    end
  end

  assign w_edge = r_tog_s ^ r_tog_d;

  always_comb begin
    w_edges_sum = r_edges;
    if (r_edges != 12'hFFF) begin
      w_edges_sum = r_edges + {11'd0, w_edge};
    end
    w_dev    = (w_edges_sum >= C_EXP) ? (w_edges_sum - C_EXP) : (C_EXP - w_edges_sum);
    w_in_tol = (w_dev <= C_TOL);
  end

  always_comb begin
    w_state_next = r_state;
    w_tmr_next   = r_tmr + 20'd1;
    w_stab_next  = r_stab;
    w_edges_next = r_edges;
    w_meas_next  = r_meas;
    w_fail       = 1'b0;
    case (r_state)
      ST_PRST: begin
        if (r_tmr == C_RST_LAST) begin
          w_state_next = ST_WLOCK;
          w_tmr_next   = 20'd0;
          w_stab_next  = 20'd0;
        end
      end
      ST_WLOCK: begin
        w_stab_next = r_lock_s ? (r_stab + 20'd1) : 20'd0;
        // Achieved stability wins over a timeout landing on the same cycle.
        if (r_lock_s && (r_stab == C_STAB_LAST)) begin
          w_state_next = ST_MEAS;
          w_tmr_next   = 20'd1;
          w_edges_next = 12'd0;
        end else if (r_tmr == C_TO_LAST) begin
          w_state_next = ST_PRST;
          w_tmr_next   = 20'd0;
          w_fail       = 1'b1;
        end
      end
      ST_MEAS, ST_RUN: begin
        // Lock loss beats window end and leaves meas untouched.
        if (!r_lock_s) begin
          w_state_next = ST_PRST;
          w_tmr_next   = 20'd0;
          w_fail       = 1'b1;
        end else if (r_tmr == C_WIN) begin
          w_meas_next  = w_edges_sum;
          w_edges_next = 12'd0;
          if (w_in_tol) begin
            w_state_next = ST_RUN;
            w_tmr_next   = 20'd1;
          end else begin
            w_state_next = ST_PRST;
            w_tmr_next   = 20'd0;
            w_fail       = 1'b1;
          end
        end else begin
          w_edges_next = w_edges_sum;
        end
      end
      default: begin
        w_state_next = ST_PRST;
        w_tmr_next   = 20'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_PRST;
      r_tmr      <= 20'd0;
      r_stab     <= 20'd0;
      r_edges    <= 12'd0;
      r_meas     <= 12'd0;
      r_fail_cnt <= 4'd0;
      r_pll_rst  <= 1'b1;
      r_sys_rst  <= 1'b1;
      r_ready    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tmr     <= w_tmr_next;
      r_stab    <= w_stab_next;
      r_edges   <= w_edges_next;
      r_meas    <= w_meas_next;
      r_pll_rst <= (w_state_next == ST_PRST);
      r_sys_rst <= (w_state_next != ST_RUN);
      r_ready   <= (w_state_next == ST_RUN);
      if (w_fail && (r_fail_cnt != 4'hF)) begin
        r_fail_cnt <= r_fail_cnt + 4'd1;
      end
    end
  end

  assign pll_if.pll_rst  = r_pll_rst;
  assign pll_if.sys_rst  = r_sys_rst;
  assign pll_if.ready    = r_ready;
  assign pll_if.fail_cnt = r_fail_cnt;
  assign pll_if.meas     = r_meas;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/pll_lock_guard.md
# pll_lock_guard

Supervisor for a fabric PLL, running in the PLL's reference-clock domain. It owns the PLL's RESET input. It watches the PLL's asynchronous lock output and a toggle signal returned from the PLL output-clock domain. It releases the synchronous system reset only after lock is stable and the measured output frequency is within tolerance. Any loss of lock, lock timeout or frequency error causes it to re-reset the PLL and retry.

## Interface
Parameters:
- RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥1).
- LOCK_STABLE, 256: consecutive cycles `lock_s` must be high before measuring.
- LOCK_TIMEOUT, 65535: cycles in WLOCK before the attempt is abandoned (≤ 2^20−1).
- WINDOW, 1000: reference cycles per frequency-measurement window (≤ 65535).
- EXP_EDGES, 240: expected toggle edges per window (12 MHz output, 6 MHz toggle, 50 MHz ref).
- TOL, 4: allowed absolute deviation of the edge count.

Ports:
- `clk` in 1: reference clock (PLL input clock).
- `reset` in 1: synchronous, active-high.
- `pll_lock` in 1: PLL lock, asynchronous.
- `fb_toggle` in 1: flop in the PLL output domain inverting every output cycle; asynchronous here.
- `pll_rst` out 1: drives the PLL RESET pin.
- `sys_rst` out 1: synchronous active-high reset for downstream logic.
- `ready` out 1: high only in RUN.
- `fail_cnt` out 4: count of failed attempts, saturating at 15.
- `meas` out 12: edge count from the last completed window.

## Operation
- Synchronizers:
  - `pll_lock` passes through 2 flops, giving `lock_s`.
  - `fb_toggle` passes through 2 flops, then a third flop; `edge` = XOR of the last two flops.
- State machine. States are PRST, WLOCK, MEAS, RUN. Reset enters PRST with all counters at 0.
- PRST:
  - `pll_rst`=1.
  - Counts RST_CYCLES cycles, then goes to WLOCK with counters cleared.
- WLOCK:
  - `pll_rst`=0.
  - Stability counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - Reaching LOCK_STABLE goes to MEAS.
  - Timeout counter increments every cycle; reaching LOCK_TIMEOUT is a failure and goes to PRST.
- MEAS and RUN: a window counter counts 1..WINDOW. The edge counter (12 bits, saturating at 4095) adds `edge` each cycle and restarts at each new window. At the cycle where the window counter equals WINDOW:
  - `meas` ← final count, including that cycle's edge.
  - If |count − EXP_EDGES| ≤ TOL: MEAS→RUN, or RUN stays in RUN with a new window started.
  - Otherwise it is a failure and goes to PRST.
- Lock loss: `lock_s`=0 in MEAS or RUN goes to PRST. This is a failure for `fail_cnt` purposes.
- Priority in one cycle: lock loss beats window end. `meas` is not updated on a lock-loss cycle.
- `fail_cnt`: +1 on every failure transition to PRST, saturating at 15. Cleared only by `reset`.
- Outputs, all registered and decoded from the next state:
  - `pll_rst`=1 iff in PRST.
  - `sys_rst`=0 iff in RUN.
  - `ready`=1 iff in RUN.
- Reset values: `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail_cnt`=0, `meas`=0, state PRST.
- `reset` asserted in any state takes effect at the next edge and restarts from PRST.

## Timing
- `pll_lock` falling before edge k: `lock_s` is low after edge k+1. `sys_rst`=1, `ready`=0 and `pll_rst`=1 after edge k+2.
- `fb_toggle` transition: counted 3 edges later.
- Minimum time from entering WLOCK to `ready`: LOCK_STABLE + WINDOW cycles.
- PRST lasts exactly RST_CYCLES cycles, measured as cycles with `pll_rst`=1.
- `meas` updates in the same cycle the state leaves or re-enters the window, and holds between windows.

## Test plan
Parameters for all tests: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=200, WINDOW=100, EXP_EDGES=24, TOL=2.
1. Nominal bring-up:
   - Stimulus: release `reset`, raise `pll_lock` 20 cycles after `pll_rst` falls, toggle `fb_toggle` every 4 cycles.
   - Required: `pll_rst` high for exactly 4 cycles; `meas`=24 or 25; `ready`=1 and `sys_rst`=0 after lock stable 8 + window 100; `fail_cnt`=0.
2. Lock timeout:
   - Stimulus: hold `pll_lock`=0.
   - Required: returns to PRST every 200 WLOCK cycles; `fail_cnt` increments each time and sticks at 15.
3. Frequency error:
   - Stimulus: toggle every 3 cycles (≈33 edges).
   - Required: `meas`≈33, transition to PRST, `fail_cnt`=1, `ready` never asserted.
4. Lock loss in RUN:
   - Stimulus: drop `pll_lock` for 1 cycle.
   - Required: `sys_rst`=1 at the 3rd edge after the drop; PRST of 4 cycles, then full re-qualification.
5. Lock glitch in WLOCK:
   - Stimulus: `pll_lock` high for 5 cycles, low for 1, then high.
   - Required: stability counter restarts; MEAS entered only after 8 consecutive high cycles.
6. Simultaneous events:
   - Stimulus: lock loss on the window-end cycle.
   - Required: PRST; `meas` unchanged.
   - Stimulus: `reset` asserted mid-MEAS.
   - Required: all outputs at reset values on the next edge; `fail_cnt`=0.
